// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: core request/response handshake onto a synchronous single-port RAM.
// Optional bus_err output for out-of-range accesses is enabled by DATA_MEM_CTRL_BUS_ERR_EN.
module data_mem_ctrl #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  request,
   input  logic                  wren,
   input  logic [WIDTH-1:0]      address,
   input  logic [WIDTH-1:0]      writedata,
   output logic                  response,
   output logic [WIDTH-1:0]      readdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wren,
   output logic                  ram_rden,
   output logic [WIDTH-1:0]      ram_wdata,
`ifdef DATA_MEM_CTRL_BUS_ERR_EN
   output logic                  bus_err,
`endif
   input  logic [WIDTH-1:0]      ram_rdata
);

   localparam int unsigned CntW = 3;

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StHold} state_e;

   state_e          state_q;
   logic            wr_q;
   logic            oor_q;
   logic [CntW-1:0] cnt_q;
   logic            oor_in;

   // Any address bit above the RAM word-address range marks the access out of range.
   assign oor_in = |(address >> ADDR_WIDTH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         wr_q      <= 1'b0;
         oor_q     <= 1'b0;
         cnt_q     <= '0;
         response  <= 1'b0;
         readdata  <= '0;
         ram_addr  <= '0;
         ram_wren  <= 1'b0;
         ram_rden  <= 1'b0;
         ram_wdata <= '0;
`ifdef DATA_MEM_CTRL_BUS_ERR_EN
         bus_err   <= 1'b0;
`endif
      end else begin
         response <= 1'b0;
         ram_wren <= 1'b0;
         ram_rden <= 1'b0;
`ifdef DATA_MEM_CTRL_BUS_ERR_EN
         bus_err  <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (request) begin
                  wr_q     <= wren;
                  oor_q    <= oor_in;
                  ram_addr <= address[ADDR_WIDTH-1:0];
                  if (wren) begin
                     ram_wdata <= writedata;
                  end
                  // RAM strobes are registered here so they are high exactly during ISSUE.
                  ram_wren <= wren & ~oor_in;
                  ram_rden <= ~wren & ~oor_in;
                  state_q  <= StIssue;
               end
            end
            StIssue: begin
               if (!wr_q) begin
                  cnt_q <= CntW'(RAM_LATENCY - 1);
               end
               if (!wr_q && (RAM_LATENCY > 1)) begin
                  state_q <= StWait;
               end else begin
                  state_q <= StResp;
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  state_q <= StResp;
               end
            end
            StResp: begin
               // ram_rdata is taken as RESP is left: RAM_LATENCY full cycles after ram_addr.
               if (!wr_q) begin
                  readdata <= oor_q ? '0 : ram_rdata;
               end
               response <= 1'b1;
`ifdef DATA_MEM_CTRL_BUS_ERR_EN
               bus_err  <= oor_q;
`endif
               state_q  <= StHold;
            end
            StHold: begin
               if (!request) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances (RAM_LATENCY 1, 3, 4) share one stimulus stream.
module tb_data_mem_ctrl;

   localparam int W  = 32;
   localparam int AW = 10;
   localparam int N  = 3;

   typedef struct {
      logic          wr;
      logic [W-1:0]  addr;
      logic [W-1:0]  wdata;
      logic [W-1:0]  rdata;
      logic          err;
      int            cyc;
      int            lat;
   } exp_t;

   exp_t exp_q[N][$];

   logic clk = 1'b0;
   logic reset;
   logic request;
   logic wren;
   logic [W-1:0] address;
   logic [W-1:0] writedata;

   logic [N-1:0]         resp;
   logic [N-1:0]         ram_wren;
   logic [N-1:0]         ram_rden;
   logic [N-1:0][W-1:0]  readdata;
   logic [N-1:0][W-1:0]  ram_wdata;
   logic [N-1:0][W-1:0]  ram_rdata;
   logic [N-1:0][AW-1:0] ram_addr;
`ifdef DATA_MEM_CTRL_BUS_ERR_EN
   logic [N-1:0]         bus_err;
`endif

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   int wr_cnt[N] = '{default: 0};
   int rd_cnt[N] = '{default: 0};
   int exp_wr[N] = '{default: 0};
   int exp_rd[N] = '{default: 0};
   bit abort_mode = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : 4;
   endfunction

   function automatic void chk(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += exp_q[i].size();
      return s;
   endfunction

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
         logic [W-1:0] mem [1 << AW];
         logic [W-1:0] pipe [4];

         data_mem_ctrl #(
            .WIDTH      (W),
            .ADDR_WIDTH (AW),
            .RAM_LATENCY(L)
         ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .request  (request),
            .wren     (wren),
            .address  (address),
            .writedata(writedata),
            .response (resp[g]),
            .readdata (readdata[g]),
            .ram_addr (ram_addr[g]),
            .ram_wren (ram_wren[g]),
            .ram_rden (ram_rden[g]),
            .ram_wdata(ram_wdata[g]),
`ifdef DATA_MEM_CTRL_BUS_ERR_EN
            .bus_err  (bus_err[g]),
`endif
            .ram_rdata(ram_rdata[g])
         );

         // RAM model: address registered on the ISSUE edge, data out L cycles later and held.
         always @(posedge clk) begin
            if (ram_wren[g]) mem[ram_addr[g]] <= ram_wdata[g];
            if (ram_rden[g]) pipe[0] <= mem[ram_addr[g]];
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
         end
         assign ram_rdata[g] = pipe[L-1];
      end
   endgenerate

   // Monitor: checks RAM strobes against the pending transaction and pops on each response.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            if (ram_wren[i]) wr_cnt[i]++;
            if (ram_rden[i]) rd_cnt[i]++;
            if ((ram_wren[i] || ram_rden[i]) && !abort_mode) begin
               chk($sformatf("u%0d wren&rden", i), W'(ram_wren[i] & ram_rden[i]), 0);
               if (exp_q[i].size() == 0) begin
                  chk($sformatf("u%0d ram access pending", i), W'(exp_q[i].size()), 1);
               end else begin
                  e = exp_q[i][0];
                  chk($sformatf("u%0d ram_addr", i), W'(ram_addr[i]), W'(e.addr[AW-1:0]));
                  chk($sformatf("u%0d issue cycle", i), cyc, e.cyc);
                  chk($sformatf("u%0d ram_wren", i), W'(ram_wren[i]), W'(e.wr));
                  if (ram_wren[i]) chk($sformatf("u%0d ram_wdata", i), ram_wdata[i], e.wdata);
               end
            end
            if (resp[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk($sformatf("u%0d response pending", i), W'(exp_q[i].size()), 1);
               end else begin
                  e = exp_q[i].pop_front();
                  chk($sformatf("u%0d readdata", i), readdata[i], e.rdata);
                  chk($sformatf("u%0d latency", i), cyc - e.cyc, e.lat);
`ifdef DATA_MEM_CTRL_BUS_ERR_EN
                  chk($sformatf("u%0d bus_err", i), W'(bus_err[i]), W'(e.err));
`endif
               end
`ifdef DATA_MEM_CTRL_BUS_ERR_EN
            end else if (bus_err[i]) begin
               chk($sformatf("u%0d bus_err idle", i), W'(bus_err[i]), 0);
`endif
            end
         end
      end
   end

   task automatic check_counts(input string tag);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("u%0d %s wren count", i, tag), wr_cnt[i], exp_wr[i]);
         chk($sformatf("u%0d %s rden count", i, tag), rd_cnt[i], exp_rd[i]);
      end
   endtask

   task automatic xact(input bit wr, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                       input logic [W-1:0] rexp, input bit err, input int hold,
                       input bit drop_early);
      exp_t e;
      bit   oor;
      int   t;
      oor = (addr >> AW) != 0;
      @(negedge clk);
      request   = 1'b1;
      wren      = wr;
      address   = addr;
      writedata = wdata;
      for (int i = 0; i < N; i++) begin
         e.wr    = wr;
         e.addr  = addr;
         e.wdata = wdata;
         e.rdata = rexp;
         e.err   = err;
         e.cyc   = cyc + 1;
         e.lat   = wr ? 2 : 1 + lat_of(i);
         exp_q[i].push_back(e);
         if (wr && !oor) exp_wr[i]++;
         if (!wr && !oor) exp_rd[i]++;
      end
      @(negedge clk);
      // Inputs change after acceptance; the controller must ignore them.
      wren      = ~wr;
      address   = ~addr;
      writedata = ~wdata;
      if (drop_early) request = 1'b0;
      t = 0;
      while (pending() != 0 && t < 30) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("responses outstanding", pending(), 0);
      repeat (hold) @(negedge clk);
      request = 1'b0;
      @(negedge clk);
      #1;
      check_counts("xact");
   endtask

   task automatic abort_read(input logic [W-1:0] addr, input int n);
      @(negedge clk);
      abort_mode = 1'b1;
      request    = 1'b1;
      wren       = 1'b0;
      address    = addr;
      for (int i = 0; i < N; i++) exp_rd[i]++;
      @(negedge clk);
      repeat (n) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("u%0d abort response", i), W'(resp[i]), 0);
         chk($sformatf("u%0d abort ram_rden", i), W'(ram_rden[i]), 0);
         chk($sformatf("u%0d abort readdata", i), readdata[i], 0);
      end
      request = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check_counts("abort");
      abort_mode = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      request   = 1'b0;
      wren      = 1'b0;
      address   = '0;
      writedata = '0;
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("u%0d reset response", i), W'(resp[i]), 0);
         chk($sformatf("u%0d reset readdata", i), readdata[i], 0);
         chk($sformatf("u%0d reset ram_addr", i), W'(ram_addr[i]), 0);
         chk($sformatf("u%0d reset ram_wdata", i), ram_wdata[i], 0);
         chk($sformatf("u%0d reset strobes", i), W'({ram_wren[i], ram_rden[i]}), 0);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;

      xact(1'b1, 32'h2,         32'h0000_0104, 32'h0,         1'b0, 0,  1'b0);
      xact(1'b0, 32'h2,         32'h0,         32'h0000_0104, 1'b0, 0,  1'b0);
      xact(1'b1, 32'h3FF,       32'hDEAD_BEEF, 32'h0000_0104, 1'b0, 0,  1'b0);
      xact(1'b0, 32'h3FF,       32'h0,         32'hDEAD_BEEF, 1'b0, 10, 1'b0);
      xact(1'b1, 32'h400,       32'h0000_0055, 32'hDEAD_BEEF, 1'b1, 0,  1'b0);
      xact(1'b0, 32'h400,       32'h0,         32'h0,         1'b1, 0,  1'b0);
      abort_read(32'h2, 0);
      abort_read(32'h3FF, 1);
      xact(1'b0, 32'h2,         32'h0,         32'h0000_0104, 1'b0, 0,  1'b0);
      xact(1'b1, 32'h0,         32'h0000_0007, 32'h0000_0104, 1'b0, 0,  1'b0);
      xact(1'b0, 32'h0,         32'h0,         32'h0000_0007, 1'b0, 0,  1'b0);
      xact(1'b0, 32'h3FF,       32'h0,         32'hDEAD_BEEF, 1'b0, 0,  1'b1);
      xact(1'b1, 32'h8000_0005, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 0,  1'b0);
      xact(1'b0, 32'h0,         32'h0,         32'h0000_0007, 1'b0, 0,  1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
